// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register plus write-back data selection.
// Drives the register-file write port one cycle after the MEM stage.
// Optional feature macro: WB_SUBWORD_LOAD_EN enables sub-word load extraction
// (LoadSize/LoadUnsigned); without it memory write-back uses the full word.
module wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iValid,
  input  logic              iStall,
  input  logic              iFlush,
  input  logic [DATA_W-1:0] iResult,
  input  logic [CTRL_W-1:0] iControlSignal,
  input  logic [DATA_W-1:0] iReadData,
  input  logic [REG_AW-1:0] iRegAddress,
  input  logic [DATA_W-1:0] iPC_plus_4,
  output logic              oValid,
  output logic              oRegWrite,
  output logic [DATA_W-1:0] oRegData,
  output logic [REG_AW-1:0] oRegAddress,
  output logic [CNT_W-1:0]  oRetireCount
);

`ifdef WB_SUBWORD_LOAD_EN
  localparam int unsigned CtrlHi = 17;
`else
  localparam int unsigned CtrlHi = 14;
`endif

  logic              valid_q;
  logic [DATA_W-1:0] result_q;
  logic [CtrlHi:8]   ctrl_q;
  logic [DATA_W-1:0] read_data_q;
  logic [REG_AW-1:0] reg_addr_q;
  logic [DATA_W-1:0] pc_plus4_q;
  logic [CNT_W-1:0]  retire_cnt_q;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] wb_data;

  // Control bits that never influence write-back are sunk here.
  logic unused_bits;
  assign unused_bits = ^{iControlSignal, ctrl_q[12:9]};

  // Stage register: flush beats stall; stall holds every field.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      result_q    <= '0;
      ctrl_q      <= '0;
      read_data_q <= '0;
      reg_addr_q  <= '0;
      pc_plus4_q  <= '0;
    end else if (iFlush) begin
      valid_q <= 1'b0;
    end else if (!iStall) begin
      valid_q     <= iValid;
      result_q    <= iResult;
      ctrl_q      <= iControlSignal[CtrlHi:8];
      read_data_q <= iReadData;
      reg_addr_q  <= iRegAddress;
      pc_plus4_q  <= iPC_plus_4;
    end
  end

  // Retire counter counts the entry leaving the stage; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt_q <= '0;
    end else if (valid_q && !iStall && !iFlush) begin
      retire_cnt_q <= retire_cnt_q + 1'b1;
    end
  end

`ifdef WB_SUBWORD_LOAD_EN
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic        sext;

  // Alignment mux and sign/zero extension for lh/lhu/lb/lbu.
  always_comb begin
    half_sel = result_q[1] ? read_data_q[31:16] : read_data_q[15:0];
    case (result_q[1:0])
      2'd0:    byte_sel = read_data_q[7:0];
      2'd1:    byte_sel = read_data_q[15:8];
      2'd2:    byte_sel = read_data_q[23:16];
      default: byte_sel = read_data_q[31:24];
    endcase
    sext     = ~ctrl_q[17];
    load_val = read_data_q;
    case (ctrl_q[16:15])
      2'b01:   load_val = {{(DATA_W-16){half_sel[15] & sext}}, half_sel};
      2'b10:   load_val = {{(DATA_W-8){byte_sel[7] & sext}}, byte_sel};
      default: load_val = read_data_q;
    endcase
  end
`else
  // Full-word loads only.
  always_comb begin
    load_val = read_data_q;
  end
`endif

  // Write-back source select: link, memory, or ALU result.
  always_comb begin
    case (ctrl_q[14:13])
      2'b10:   wb_data = pc_plus4_q;
      2'b01:   wb_data = load_val;
      default: wb_data = result_q;
    endcase
  end

  assign oValid       = valid_q;
  assign oRegWrite    = valid_q & ctrl_q[8] & (reg_addr_q != '0);
  assign oRegData     = wb_data;
  assign oRegAddress  = reg_addr_q;
  assign oRetireCount = retire_cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage (retire counter built 4 bits wide to reach wrap).
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        iValid, iStall, iFlush;
  logic [31:0] iResult, iControlSignal, iReadData, iPC_plus_4;
  logic [4:0]  iRegAddress;
  logic        oValid, oRegWrite;
  logic [31:0] oRegData;
  logic [4:0]  oRegAddress;
  logic [3:0]  oRetireCount;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_cnt = '0;
  logic        exp_valid = 1'b0;

  localparam logic [31:0] RW = 32'h100, LINK = 32'h4000, MEM = 32'h2000;
  localparam logic [31:0] HALF = 32'h8000, BYTE = 32'h10000, UNS = 32'h20000;

  wb_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(32), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .iValid(iValid), .iStall(iStall), .iFlush(iFlush),
    .iResult(iResult), .iControlSignal(iControlSignal), .iReadData(iReadData),
    .iRegAddress(iRegAddress), .iPC_plus_4(iPC_plus_4), .oValid(oValid),
    .oRegWrite(oRegWrite), .oRegData(oRegData), .oRegAddress(oRegAddress),
    .oRetireCount(oRetireCount)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic s, input logic f, input logic [31:0] res,
                       input logic [31:0] ctl, input logic [31:0] rd, input logic [4:0] ra,
                       input logic [31:0] pc);
    iValid = v; iStall = s; iFlush = f; iResult = res; iControlSignal = ctl;
    iReadData = rd; iRegAddress = ra; iPC_plus_4 = pc;
  endtask

  // Advance one edge, tracking which entry the stage should hold and the count.
  task automatic step();
    if (!reset) begin
      if (exp_valid && !iStall && !iFlush) exp_cnt = exp_cnt + 4'd1;
      exp_valid = iFlush ? 1'b0 : (iStall ? exp_valid : iValid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", oValid); end
    checks++; if (oRegWrite !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", oRegWrite); end
    checks++; if (oRegData !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", oRegData); end
    checks++; if (oRegAddress !== 5'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", oRegAddress); end
    checks++; if (oRetireCount !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", oRetireCount); end
    reset = 1'b0;
    exp_cnt = '0; exp_valid = 1'b0;
    step();
  endtask

  task automatic test_alu();
    drive(1, 0, 0, 32'h12345678, RW, 32'hCAFEF00D, 5'd9, 32'h00400004);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (oRegWrite !== 1'b1) begin errors++; $display("FAIL alu_we got %b want 1", oRegWrite); end
    checks++; if (oRegAddress !== 5'd9) begin errors++; $display("FAIL alu_addr got %0d want 9", oRegAddress); end
    checks++; if (oRegData !== 32'h12345678) begin errors++; $display("FAIL alu_data got %h want 12345678", oRegData); end
    checks++; if (oRetireCount !== 4'd0) begin errors++; $display("FAIL alu_cnt0 got %0d want 0", oRetireCount); end
    step();
    checks++; if (oRetireCount !== 4'd1) begin errors++; $display("FAIL alu_cnt1 got %0d want 1", oRetireCount); end
    checks++; if (oRegWrite !== 1'b0) begin errors++; $display("FAIL alu_bubble_we got %b want 0", oRegWrite); end
  endtask

  task automatic test_link_zero();
    drive(1, 0, 0, 32'hDEADBEEF, RW | LINK, 32'h11111111, 5'd31, 32'h00400008);
    step();
    checks++; if (oRegData !== 32'h00400008) begin errors++; $display("FAIL link_data got %h want 00400008", oRegData); end
    checks++; if (oRegWrite !== 1'b1) begin errors++; $display("FAIL link_we got %b want 1", oRegWrite); end
    checks++; if (oRegAddress !== 5'd31) begin errors++; $display("FAIL link_addr got %0d want 31", oRegAddress); end
    drive(1, 0, 0, 32'hDEADBEEF, RW | LINK, 32'h11111111, 5'd0, 32'h00400008);
    step();
    checks++; if (oRegWrite !== 1'b0) begin errors++; $display("FAIL zero_we got %b want 0", oRegWrite); end
    checks++; if (oValid !== 1'b1) begin errors++; $display("FAIL zero_valid got %b want 1", oValid); end
    // Memory path plus RegWrite=0 must still drive data but not write.
    drive(1, 0, 0, 32'h0, MEM, 32'h13572468, 5'd4, 32'h0);
    step();
    checks++; if (oRegWrite !== 1'b0) begin errors++; $display("FAIL norw_we got %b want 0", oRegWrite); end
    checks++; if (oRegData !== 32'h13572468) begin errors++; $display("FAIL norw_data got %h want 13572468", oRegData); end
  endtask

  task automatic test_subword();
    logic [31:0] ctl [8];
    logic [31:0] off [8];
    logic [31:0] want [8];
    ctl[0] = BYTE;        off[0] = 3; want[0] = 32'hFFFFFF80;
    ctl[1] = BYTE | UNS;  off[1] = 3; want[1] = 32'h00000080;
    ctl[2] = HALF;        off[2] = 2; want[2] = 32'hFFFF80FF;
    ctl[3] = HALF | UNS;  off[3] = 0; want[3] = 32'h00007F01;
    ctl[4] = BYTE;        off[4] = 1; want[4] = 32'h0000007F;
    ctl[5] = BYTE;        off[5] = 2; want[5] = 32'hFFFFFFFF;
    ctl[6] = HALF | UNS;  off[6] = 2; want[6] = 32'h000080FF;
    ctl[7] = UNS;         off[7] = 0; want[7] = 32'h80FF7F01;
`ifndef WB_SUBWORD_LOAD_EN
    for (int i = 0; i < 8; i++) want[i] = 32'h80FF7F01;
`endif
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 32'h10000000 | off[i], RW | MEM | ctl[i], 32'h80FF7F01, 5'd8 + i[4:0],
            32'h0);
      step();
      checks++;
      if (oRegData !== want[i]) begin
        errors++; $display("FAIL load_%0d got %h want %h", i, oRegData, want[i]);
      end
    end
    checks++; if (oRetireCount !== exp_cnt) begin errors++; $display("FAIL load_cnt got %0d want %0d", oRetireCount, exp_cnt); end
  endtask

  task automatic test_stall();
    logic [3:0] held;
    drive(1, 0, 0, 32'hA5A5A5A5, RW, 0, 5'd5, 0);
    step();
    held = exp_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 32'h5A5A0000 + i, RW | LINK, 0, 5'd20 + i[4:0], 32'h77777777);
      step();
      checks++; if (oRegData !== 32'hA5A5A5A5) begin errors++; $display("FAIL stall_data got %h want a5a5a5a5", oRegData); end
      checks++; if (oRegAddress !== 5'd5) begin errors++; $display("FAIL stall_addr got %0d want 5", oRegAddress); end
      checks++; if (oRegWrite !== 1'b1) begin errors++; $display("FAIL stall_we got %b want 1", oRegWrite); end
      checks++; if (oRetireCount !== held) begin errors++; $display("FAIL stall_cnt got %0d want %0d", oRetireCount, held); end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checks++; if (oRetireCount !== held + 4'd1) begin errors++; $display("FAIL unstall_cnt got %0d want %0d", oRetireCount, held + 4'd1); end
  endtask

  task automatic test_flush();
    logic [3:0] held;
    drive(1, 0, 0, 32'h0BADCAFE, RW, 0, 5'd6, 0);
    step();
    held = exp_cnt;
    drive(1, 1, 1, 32'h1, RW, 0, 5'd7, 0);
    step();
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL flushstall_valid got %b want 0", oValid); end
    checks++; if (oRegWrite !== 1'b0) begin errors++; $display("FAIL flushstall_we got %b want 0", oRegWrite); end
    checks++; if (oRetireCount !== held) begin errors++; $display("FAIL flushstall_cnt got %0d want %0d", oRetireCount, held); end
    drive(1, 0, 1, 32'h2, RW, 0, 5'd7, 0);
    step();
    checks++; if (oRegWrite !== 1'b0) begin errors++; $display("FAIL flush_we got %b want 0", oRegWrite); end
    checks++; if (oRetireCount !== held) begin errors++; $display("FAIL flush_cnt got %0d want %0d", oRetireCount, held); end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 0, 32'h600DF00D, RW, 0, 5'd12, 0);
    step();
    drive(1, 1, 0, 32'h600DF00D, RW, 0, 5'd12, 0);
    #2 reset = 1'b1;
    #1;
    checks++; if (oValid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", oValid); end
    checks++; if (oRegWrite !== 1'b0) begin errors++; $display("FAIL areset_we got %b want 0", oRegWrite); end
    checks++; if (oRegData !== 32'h0) begin errors++; $display("FAIL areset_data got %h want 0", oRegData); end
    checks++; if (oRetireCount !== 4'd0) begin errors++; $display("FAIL areset_cnt got %0d want 0", oRetireCount); end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = '0; exp_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, 32'h100 * i, RW, 0, 5'd1 + i[4:0], 0);
      step();
      checks++;
      if (oRegData !== 32'h100 * i) begin
        errors++; $display("FAIL b2b_data_%0d got %h want %h", i, oRegData, 32'h100 * i);
      end
    end
    checks++; if (oRetireCount !== 4'd15) begin errors++; $display("FAIL b2b_cnt15 got %0d want 15", oRetireCount); end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    checks++; if (oRetireCount !== 4'd0) begin errors++; $display("FAIL b2b_wrap got %0d want 0", oRetireCount); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_link_zero();
    test_subword();
    test_stall();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Parametrised, registered write-back stage of the MIPS pipeline: the MEM/WB pipeline register and the write-back selection logic in one block. Captures the MEM-stage result, load data, destination register and link address, then drives the register-file write port one cycle later. Supports stall/flush, sub-word load extraction, zero-register write suppression and a retired-instruction counter. Sits between the MEM stage and the register file; its write port also feeds the ID-stage forwarding unit.

## Interface
- DATA_W, 32: datapath width; sub-word loads require DATA_W = 32
- REG_AW, 5: register address width
- CTRL_W, 32: control word width; must be ≥ 18
- CNT_W, 32: retire counter width
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- iValid  in  1  MEM stage presents a real instruction
- iStall  in  1  hold the stage register
- iFlush  in  1  squash the incoming entry
- iResult  in  DATA_W  ALU result / memory address
- iControlSignal  in  CTRL_W  control word: [8] RegWrite, [14:13] MemtoReg (10 = link, 01 = memory, other = ALU), [16:15] LoadSize (00 = word, 01 = half, 10 = byte, 11 = word), [17] LoadUnsigned
- iReadData  in  DATA_W  raw aligned word from data memory
- iRegAddress  in  REG_AW  destination register
- iPC_plus_4  in  DATA_W  link value
- oValid  out  1  stage register holds a valid entry
- oRegWrite  out  1  register-file write enable
- oRegData  out  DATA_W  register-file write data
- oRegAddress  out  REG_AW  register-file write address
- oRetireCount  out  CNT_W  retired-instruction count

## Operation
- Stage register fields: valid, result, ctrl[17:8], readData, regAddr, pcPlus4.
- Each rising edge: if iFlush, set valid = 0 (other fields don't-care). Else if iStall, hold all fields. Else capture all inputs, with valid = iValid.
- iFlush has priority over iStall.
- Write select, combinational from the register:
  - MemtoReg = 10: pcPlus4
  - MemtoReg = 01: load value
  - otherwise: result
- Load value with LoadSize = 01: select the halfword at result[1], where 0 selects the low half.
- Load value with LoadSize = 10: select the byte at result[1:0], where 0 selects the least significant byte.
- Sub-word extension: sign-extend if LoadUnsigned = 0, zero-extend if 1.
- LoadSize 00 or 11: pass the full word.
- oRegWrite = valid & ctrl[8] & (regAddr ≠ 0).
- oRegAddress = regAddr.
- oRegData is driven regardless of oRegWrite.
- A stalled entry re-drives the same write each cycle. This is idempotent and intended.
- Retire counter increments on each edge where valid = 1 and iStall = 0 and iFlush = 0. It wraps from 2^CNT_W − 1 to 0.

## Timing
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Reset values: oValid = 0, oRegWrite = 0, oRegData = 0, oRegAddress = 0, oRetireCount = 0, and all stage fields = 0.
- Reset asserted mid-operation drops the held entry at once; no write occurs.
- First capture happens at the first rising edge after reset deasserts.
- Flush and stall in the same cycle: entry squashed, counter unchanged.
- A flushed entry never produces oRegWrite = 1, even when iValid = 1.
- Counter increment and new capture happen on the same edge. The count reflects the entry leaving the stage.

## Configuration
- WB_SUBWORD_LOAD_EN defined: LoadSize/LoadUnsigned extraction as described. Stage register holds ctrl[17:8].
- WB_SUBWORD_LOAD_EN undefined:
  - ctrl[17:15] are ignored and not stored.
  - Memory write-back always uses the full readData word.
  - The alignment mux is not built.
  - The block is legal for any DATA_W.

## Test plan
- Reset: assert reset mid-stream with a valid entry held -> oValid = 0, oRegWrite = 0, oRegData = 0, oRetireCount = 0 immediately, without waiting for a clock edge.
- ALU path: iValid = 1, ctrl[8] = 1, MemtoReg = 00, iResult = 0x12345678, iRegAddress = 9 -> next cycle oRegWrite = 1, oRegAddress = 9, oRegData = 0x12345678, and oRetireCount becomes 1 on the following edge.
- Link and $zero:
  - MemtoReg = 10, iPC_plus_4 = 0x00400008, iRegAddress = 31 -> oRegData = 0x00400008.
  - Same entry with iRegAddress = 0 -> oRegWrite = 0.
- Sub-word loads, all with iReadData = 0x80FF7F01 (macro defined):
  - lb, offset 3 -> 0xFFFFFF80
  - lbu, offset 3 -> 0x00000080
  - lh, offset 2 -> 0xFFFF80FF
  - lhu, offset 0 -> 0x00007F01
  - With the macro undefined, every case -> 0x80FF7F01.
- Stall/flush:
  - Stall 3 cycles while the inputs change -> outputs hold the original entry and the counter is frozen.
  - Flush together with stall -> oValid = 0 next cycle and the counter is unchanged.
- Counter wrap: CNT_W = 4, run 16 back-to-back valid unstalled entries -> oRetireCount returns to 0.
